game_ctrl: RTL and testbench

// - Top-level game sequencer. Owns the game state (menu / play / pause / respawn / game over) and gates the drawing and movement datapath.
// - Takes decoded keyboard events, VGA vsync and game-logic flags (collision, goal).
// - Drives layer enables for draw_menu / draw_donkey, movement enable, sprite respawn pulse, lives and level.
// - Sits in top_game between ps2_keyboard_to_ascii (via upstream CDC) and the draw/movement chain.

---
 rtl/game_pkg.sv | 16 +
 rtl/frame_tick_gen.sv | 33 +++
 rtl/game_ctrl.sv | 160 ++++++++++++++++
 tb/tb_game_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game-state encoding and keyboard command codes for the game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        PLAY      = 3'd1,
        PAUSE     = 3'd2,
        RESPAWN   = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    localparam logic [6:0] KEY_START = 7'h0D;
    localparam logic [6:0] KEY_PAUSE = 7'h70;
    localparam logic [6:0] KEY_QUIT  = 7'h1B;

endpackage

// File: rtl/frame_tick_gen.sv
// Turns the VGA vsync level into a single-cycle registered pulse per frame.
module frame_tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q1_q, vsync_q2_q, tick_q;
    logic vsync_q1_d, vsync_q2_d, tick_d;

    // Rising edge seen between the two vsync stages; the pulse itself is a flop.
    always_comb begin
        vsync_q1_d = vsync;
        vsync_q2_d = vsync_q1_q;
        tick_d     = vsync_q1_q & ~vsync_q2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_q1_q <= 1'b0;
            vsync_q2_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            vsync_q1_q <= vsync_q1_d;
            vsync_q2_q <= vsync_q2_d;
            tick_q     <= tick_d;
        end
    end

    assign frame_tick = tick_q;

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: menu/play/pause/respawn/game-over FSM with lives, level and frame timer.
module game_ctrl
    import game_pkg::*;
#(
    parameter int LIVES           = 3,
    parameter int NUM_LEVELS      = 4,
    parameter int RESPAWN_FRAMES  = 60,
    parameter int GAMEOVER_FRAMES = 180
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] key_code,
    input  logic       key_valid,
    input  logic       vsync,
    input  logic       collision,
    input  logic       goal_reached,
    output logic [2:0] state,
    output logic       menu_en,
    output logic       play_en,
    output logic       sprite_reset,
    output logic       frame_tick,
    output logic [1:0] lives,
    output logic [2:0] level,
    output logic       win
);

    game_state_t state_q, state_d;
    logic [1:0]  lives_q, lives_d;
    logic [2:0]  level_q, level_d;
    logic [7:0]  timer_q, timer_d;
    logic        win_q, win_d;
    logic        menu_en_q, menu_en_d;
    logic        play_en_q, play_en_d;
    logic        sprite_reset_q, sprite_reset_d;
    logic        reset_req;
    logic        tick;
    logic        key_start, key_pause, key_quit;

    frame_tick_gen u_frame_tick_gen (
        .clk        (clk),
        .rst        (rst),
        .vsync      (vsync),
        .frame_tick (tick)
    );

    // key_code is only meaningful in the single cycle key_valid is high; no back-pressure.
    assign key_start = key_valid && (key_code == KEY_START);
    assign key_pause = key_valid && (key_code == KEY_PAUSE);
    assign key_quit  = key_valid && (key_code == KEY_QUIT);

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        level_d   = level_q;
        win_d     = win_q;
        timer_d   = timer_q;
        reset_req = 1'b0;
        case (state_q)
            MENU: begin
                if (key_start) begin
                    state_d   = PLAY;
                    lives_d   = 2'(LIVES);
                    level_d   = 3'd0;
                    win_d     = 1'b0;
                    reset_req = 1'b1;
                end
            end
            PLAY: begin
                if (key_pause) begin
                    state_d = PAUSE;
                end else if (tick && goal_reached) begin
                    if (level_q < 3'(NUM_LEVELS - 1)) begin
                        level_d   = level_q + 3'd1;
                        reset_req = 1'b1;
                    end else begin
                        win_d   = 1'b1;
                        state_d = GAME_OVER;
                    end
                end else if (tick && collision) begin
                    if (lives_q > 2'd1) begin
                        lives_d   = lives_q - 2'd1;
                        reset_req = 1'b1;
                        state_d   = RESPAWN;
                    end else begin
                        lives_d = 2'd0;
                        win_d   = 1'b0;
                        state_d = GAME_OVER;
                    end
                end
            end
            PAUSE: begin
                if (key_pause) begin
                    state_d = PLAY;
                end else if (key_quit) begin
                    state_d = MENU;
                end
            end
            RESPAWN: begin
                if (tick) begin
                    if (timer_q == 8'(RESPAWN_FRAMES - 1)) begin
                        state_d = PLAY;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            GAME_OVER: begin
                if (key_start) begin
                    state_d = MENU;
                end else if (tick) begin
                    if (timer_q == 8'(GAMEOVER_FRAMES - 1)) begin
                        state_d = MENU;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            default: state_d = MENU;
        endcase
        // Every state starts counting frames from zero.
        if (state_d != state_q) begin
            timer_d = 8'd0;
        end
        sprite_reset_d = reset_req & ~sprite_reset_q;
        menu_en_d      = (state_d == MENU) || (state_d == GAME_OVER);
        play_en_d      = (state_d == PLAY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= MENU;
            lives_q        <= 2'd0;
            level_q        <= 3'd0;
            timer_q        <= 8'd0;
            win_q          <= 1'b0;
            menu_en_q      <= 1'b1;
            play_en_q      <= 1'b0;
            sprite_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            lives_q        <= lives_d;
            level_q        <= level_d;
            timer_q        <= timer_d;
            win_q          <= win_d;
            menu_en_q      <= menu_en_d;
            play_en_q      <= play_en_d;
            sprite_reset_q <= sprite_reset_d;
        end
    end

    assign state        = state_q;
    assign lives        = lives_q;
    assign level        = level_q;
    assign win          = win_q;
    assign menu_en      = menu_en_q;
    assign play_en      = play_en_q;
    assign sprite_reset = sprite_reset_q;
    assign frame_tick   = tick;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl: expected output snapshots are queued by the driver
// and popped by a monitor each time the observable game outputs change.
module tb_game_ctrl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] key_code = 7'd0;
    logic       key_valid = 1'b0;
    logic       vsync = 1'b0;
    logic       collision = 1'b0;
    logic       goal_reached = 1'b0;
    logic [2:0] state;
    logic       menu_en, play_en, sprite_reset, frame_tick, win;
    logic [1:0] lives;
    logic [2:0] level;

    int          checks = 0;
    int          passes = 0;
    int          sr_seen = 0;
    int          sr_exp = 0;
    logic        mon_on = 1'b0;
    logic [10:0] exp_q[$];

    localparam logic [6:0] KEY_A = 7'h61;

    game_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .key_code     (key_code),
        .key_valid    (key_valid),
        .vsync        (vsync),
        .collision    (collision),
        .goal_reached (goal_reached),
        .state        (state),
        .menu_en      (menu_en),
        .play_en      (play_en),
        .sprite_reset (sprite_reset),
        .frame_tick   (frame_tick),
        .lives        (lives),
        .level        (level),
        .win          (win)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [10:0] snap(input logic [2:0] st, input logic [1:0] lv,
                                         input logic [2:0] lvl, input logic w);
        logic m, p;
        m = (st == MENU) || (st == GAME_OVER);
        p = (st == PLAY);
        return {st, m, p, lv, lvl, w};
    endfunction

    function automatic logic [10:0] dut_snap();
        return {state, menu_en, play_en, lives, level, win};
    endfunction

    // One vsync pulse; flags held through the tick, optional key on the tick cycle.
    task automatic frame(input logic c, input logic g, input logic kv, input logic [6:0] kc);
        repeat (3) @(posedge clk);
        #1 vsync = 1'b1; collision = c; goal_reached = g;
        repeat (2) @(posedge clk);
        #1 key_valid = kv; key_code = kc;
        @(posedge clk);
        #1 vsync = 1'b0; collision = 1'b0; goal_reached = 1'b0; key_valid = 1'b0;
    endtask

    task automatic key(input logic [6:0] kc);
        @(posedge clk);
        #1 key_valid = 1'b1; key_code = kc;
        @(posedge clk);
        #1 key_valid = 1'b0;
    endtask

    task automatic frames(input int n, input logic c);
        for (int i = 0; i < n; i++) frame(c, 1'b0, (i % 7) == 3, KEY_A);
    endtask

    // Monitor: every change of the observable outputs must match the next queued snapshot.
    initial begin
        logic [10:0] prev, cur;
        logic        sr_prev;
        wait (mon_on);
        @(negedge clk);
        prev = dut_snap();
        sr_prev = sprite_reset;
        forever begin
            @(negedge clk);
            cur = dut_snap();
            if (sprite_reset) begin
                sr_seen++;
                check("sprite_reset_gap", {31'd0, sr_prev}, 32'd0);
            end
            sr_prev = sprite_reset;
            if (cur !== prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_event: got %h with no expected change queued", cur);
                end else begin
                    check("event", {21'd0, cur}, {21'd0, exp_q.pop_front()});
                end
            end
            prev = cur;
        end
    end

    initial begin
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {29'd0, state}, {29'd0, MENU});
        check("reset_flags", {27'd0, menu_en, play_en, sprite_reset, frame_tick, win}, 32'b10000);
        check("reset_counts", {27'd0, lives, level}, 32'd0);
        rst = 1'b0;
        mon_on = 1'b1;
        repeat (3) @(posedge clk);

        // frame_tick latency: registered twice, pulse two edges after vsync rises
        #1 vsync = 1'b1;
        @(posedge clk); #1 check("tick_edge1", {31'd0, frame_tick}, 32'd0);
        @(posedge clk); #1 check("tick_edge2", {31'd0, frame_tick}, 32'd1);
        @(posedge clk); #1 check("tick_edge3", {31'd0, frame_tick}, 32'd0);
        vsync = 1'b0;

        // Start and die three times
        key(KEY_A);
        exp_q.push_back(snap(PLAY, 2'd3, 3'd0, 1'b0)); sr_exp++;
        key(KEY_START);
        for (int life = 3; life > 1; life--) begin
            exp_q.push_back(snap(RESPAWN, 2'(life - 1), 3'd0, 1'b0)); sr_exp++;
            frame(1'b1, 1'b0, 1'b0, 7'd0);
            frames(59, 1'b1);
            check("respawn_hold", {29'd0, state, play_en}, {28'd0, RESPAWN, 1'b0});
            exp_q.push_back(snap(PLAY, 2'(life - 1), 3'd0, 1'b0));
            frame(1'b0, 1'b0, 1'b0, 7'd0);
        end
        exp_q.push_back(snap(GAME_OVER, 2'd0, 3'd0, 1'b0));
        frame(1'b1, 1'b0, 1'b0, 7'd0);
        check("die_win", {31'd0, win}, 32'd0);

        // Game-over timeout
        frames(179, 1'b0);
        check("gameover_hold", {29'd0, state}, {29'd0, GAME_OVER});
        exp_q.push_back(snap(MENU, 2'd0, 3'd0, 1'b0));
        frame(1'b0, 1'b0, 1'b0, 7'd0);
        check("gameover_timeout", {29'd0, state}, {29'd0, MENU});

        // Levels, with goal + collision together on the first tick
        exp_q.push_back(snap(PLAY, 2'd3, 3'd0, 1'b0)); sr_exp++;
        key(KEY_START);
        exp_q.push_back(snap(PLAY, 2'd3, 3'd1, 1'b0)); sr_exp++;
        frame(1'b1, 1'b1, 1'b0, 7'd0);
        exp_q.push_back(snap(PLAY, 2'd3, 3'd2, 1'b0)); sr_exp++;
        frame(1'b0, 1'b1, 1'b0, 7'd0);
        exp_q.push_back(snap(PLAY, 2'd3, 3'd3, 1'b0)); sr_exp++;
        frame(1'b0, 1'b1, 1'b0, 7'd0);
        exp_q.push_back(snap(GAME_OVER, 2'd3, 3'd3, 1'b1));
        frame(1'b0, 1'b1, 1'b0, 7'd0);

        // Early exit from GAME_OVER on the 10th tick
        frames(9, 1'b0);
        check("early_hold", {29'd0, state}, {29'd0, GAME_OVER});
        exp_q.push_back(snap(MENU, 2'd3, 3'd3, 1'b1));
        frame(1'b0, 1'b0, 1'b1, KEY_START);
        check("early_exit", {29'd0, state}, {29'd0, MENU});

        // Pause + collision on one tick, long pause, resume, quit
        exp_q.push_back(snap(PLAY, 2'd3, 3'd0, 1'b0)); sr_exp++;
        key(KEY_START);
        exp_q.push_back(snap(PAUSE, 2'd3, 3'd0, 1'b0));
        frame(1'b1, 1'b0, 1'b1, KEY_PAUSE);
        frames(100, 1'b1);
        check("pause_hold", {27'd0, state, lives}, {27'd0, PAUSE, 2'd3});
        exp_q.push_back(snap(PLAY, 2'd3, 3'd0, 1'b0));
        key(KEY_PAUSE);
        key(KEY_A);
        exp_q.push_back(snap(PAUSE, 2'd3, 3'd0, 1'b0));
        key(KEY_PAUSE);
        exp_q.push_back(snap(MENU, 2'd3, 3'd0, 1'b0));
        key(KEY_QUIT);
        key(KEY_A);
        frame(1'b1, 1'b1, 1'b0, 7'd0);

        // Asynchronous reset mid-PLAY
        exp_q.push_back(snap(PLAY, 2'd3, 3'd0, 1'b0)); sr_exp++;
        key(KEY_START);
        exp_q.push_back(snap(PLAY, 2'd3, 3'd1, 1'b0)); sr_exp++;
        frame(1'b0, 1'b1, 1'b0, 7'd0);
        @(posedge clk);
        exp_q.push_back(snap(MENU, 2'd0, 3'd0, 1'b0));
        #1 rst = 1'b1;
        #1;
        check("async_reset", {21'd0, dut_snap()}, {21'd0, snap(MENU, 2'd0, 3'd0, 1'b0)});
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        repeat (10) @(posedge clk);
        check("queue_empty", exp_q.size(), 32'd0);
        check("sprite_pulses", sr_seen, sr_exp);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
